alu_share_arbiter: RTL and testbench

Shares one combinational ALU (4-bit op code, 32-bit srcA/srcB, ALUResult, 4-bit flags {N,Z,C,V}) between two requesters, e.g. the execute-stage integer path and the branch-compare path.
Arbitration is round-robin with valid/ready request handshakes. Each requester has a single-entry registered response slot with its own valid/ready handshake.
At most one operation is issued to the ALU per cycle.

---
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters, each with a one-entry response slot.
// Latency: request accepted in cycle T, response valid in cycle T+1; one ALU issue per cycle in total.
// Backpressure: a requester with a full slot that is not being drained is not granted; the other may still issue.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic [DATA_W-1:0] alu_srcA,
  output logic [DATA_W-1:0] alu_srcB,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [15:0]       grant_count
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
  } slot_t;

  slot_t slot0, slot1;
  logic  last_grant;   // index of the most recent winner; 1 after reset so requester 0 wins the first tie
  logic  elig0, elig1;
  logic  grant0, grant1;

  // A slot being drained this cycle counts as free, so drain-and-reload is back-to-back.
  assign elig0 = req0_valid && (!slot0.vld || rsp0_ready);
  assign elig1 = req1_valid && (!slot1.vld || rsp1_ready);

  // Round-robin pick; nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Steer the winner's operands to the ALU; idle cycles drive zeros.
  always_comb begin
    alu_srcA = '0;
    alu_srcB = '0;
    alu_ctrl = '0;
    if (grant0) begin
      alu_srcA = req0_a;
      alu_srcB = req0_b;
      alu_ctrl = req0_op;
    end else if (grant1) begin
      alu_srcA = req1_a;
      alu_srcB = req1_b;
      alu_ctrl = req1_op;
    end
  end

  // Capture the ALU output into the winner's slot, retire drained slots, advance pointer and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0       <= '0;
      slot1       <= '0;
      last_grant  <= 1'b1;
      grant_count <= '0;
    end else begin
      if (grant0) begin
        slot0.vld    <= 1'b1;
        slot0.result <= alu_result;
        slot0.flags  <= alu_flags;
      end else if (rsp0_ready) begin
        slot0.vld <= 1'b0;
      end
      if (grant1) begin
        slot1.vld    <= 1'b1;
        slot1.result <= alu_result;
        slot1.flags  <= alu_flags;
      end else if (rsp1_ready) begin
        slot1.vld <= 1'b0;
      end
      if (grant0 || grant1) begin
        last_grant  <= grant1;
        grant_count <= grant_count + 16'd1;
      end
    end
  end

  assign rsp0_valid  = slot0.vld;
  assign rsp0_result = slot0.result;
  assign rsp0_flags  = slot0.flags;
  assign rsp1_valid  = slot1.vld;
  assign rsp1_result = slot1.result;
  assign rsp1_flags  = slot1.flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: directed checks of arbitration order, response slots, stalls, idle cycles and reset for alu_share_arbiter.
// Latency: expects responses one cycle after acceptance.
// Backpressure: exercises stalled and drain-and-reload response slots.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic [15:0] grant_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .grant_count(grant_count)
  );

  // Reference ALU attached to the arbiter's ALU port; flags are {N,Z,C,V}.
  logic [32:0] sum33, dif33;
  logic        c_f, v_f;
  always_comb begin
    sum33 = {1'b0, alu_srcA} + {1'b0, alu_srcB};
    dif33 = {1'b0, alu_srcA} + {1'b0, ~alu_srcB} + 33'd1;
    c_f = 1'b0;
    v_f = 1'b0;
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: begin
        alu_result = sum33[31:0];
        c_f = sum33[32];
        v_f = (alu_srcA[31] == alu_srcB[31]) && (sum33[31] != alu_srcA[31]);
      end
      4'b0001: begin
        alu_result = dif33[31:0];
        c_f = dif33[32];
        v_f = (alu_srcA[31] != alu_srcB[31]) && (dif33[31] != alu_srcA[31]);
      end
      4'b0010: alu_result = alu_srcA & alu_srcB;
      4'b0011: alu_result = alu_srcA | alu_srcB;
      4'b0100: alu_result = {31'd0, $signed(alu_srcA) < $signed(alu_srcB)};
      4'b0101: alu_result = alu_srcA << alu_srcB[4:0];
      4'b0110: alu_result = {31'd0, alu_srcA < alu_srcB};
      4'b0111: alu_result = alu_srcA ^ alu_srcB;
      4'b1000: alu_result = alu_srcA >> alu_srcB[4:0];
      4'b1001: alu_result = $unsigned($signed(alu_srcA) >>> alu_srcB[4:0]);
      default: alu_result = '0;
    endcase
    alu_flags = {alu_result[31], alu_result == 32'd0, c_f, v_f};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    step();
    // Reset state, and no grant while reset is held even with a request pending.
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0000;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    step();
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_flags", rsp1_flags, 0);
    chk("rst_count", grant_count, 0);

    // 1: requester 0 alone, ADD 5+3.
    rst = 0;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_alu_srcA", alu_srcA, 5);
    step();
    req0_valid = 0;
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_result", rsp0_result, 8);
    chk("t1_rsp0_flags", rsp0_flags, 4'b0000);
    chk("t1_count", grant_count, 1);

    // 2: requester 1 alone, SUB 3-3 then SLT 1<2; rsp0 drains meanwhile.
    rsp0_ready = 1;
    req1_valid = 1; req1_a = 32'd3; req1_b = 32'd3; req1_op = 4'b0001;
    #1;
    chk("t2_req1_ready", req1_ready, 1);
    step();
    chk("t2_rsp1_result_sub", rsp1_result, 0);
    chk("t2_rsp1_flags_sub", rsp1_flags, 4'b0110);
    chk("t2_rsp0_drained", rsp0_valid, 0);
    rsp1_ready = 1;
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0100;
    #1;
    chk("t2_req1_ready_reload", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t2_rsp1_valid", rsp1_valid, 1);
    chk("t2_rsp1_result_slt", rsp1_result, 1);
    chk("t2_count", grant_count, 3);
    step();
    chk("t2_rsp1_drained", rsp1_valid, 0);

    // 3: both requesting from reset, slots always drained: grants alternate 0,1,0,1.
    do_reset();
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 4'b0000;
    req1_valid = 1; req1_a = 32'd10; req1_b = 32'd1; req1_op = 4'b0001;
    #1;
    chk("t3_g1_req0", req0_ready, 1);
    chk("t3_g1_req1", req1_ready, 0);
    step();
    chk("t3_e1_rsp0", rsp0_valid, 1);
    chk("t3_e1_rsp1", rsp1_valid, 0);
    chk("t3_e1_res0", rsp0_result, 11);
    chk("t3_g2_req1", req1_ready, 1);
    step();
    chk("t3_e2_rsp0", rsp0_valid, 0);
    chk("t3_e2_rsp1", rsp1_valid, 1);
    chk("t3_e2_res1", rsp1_result, 9);
    chk("t3_g3_req0", req0_ready, 1);
    step();
    chk("t3_e3_rsp0", rsp0_valid, 1);
    chk("t3_g4_req1", req1_ready, 1);
    step();
    chk("t3_e4_rsp0", rsp0_valid, 0);
    chk("t3_e4_rsp1", rsp1_valid, 1);
    chk("t3_count", grant_count, 4);

    // 4: rsp0 stalled; requester 1 keeps issuing, then raising rsp0_ready drains and reloads.
    rsp0_ready = 0;
    req0_a = 32'd20; req0_b = 32'd2; req0_op = 4'b0001;
    #1;
    chk("t4_tie_req0", req0_ready, 1);
    step();
    chk("t4_rsp0_result", rsp0_result, 18);
    chk("t4_rsp0_flags", rsp0_flags, 4'b0010);
    req0_a = 32'd99; req0_b = 32'd1; req0_op = 4'b0000;
    req1_a = 32'd6; req1_b = 32'd3; req1_op = 4'b0010;
    #1;
    chk("t4_stall_req0", req0_ready, 0);
    chk("t4_stall_req1", req1_ready, 1);
    step();
    chk("t4_and_res1", rsp1_result, 2);
    chk("t4_hold_res0", rsp0_result, 18);
    req1_op = 4'b0011;
    #1;
    chk("t4_stall2_req0", req0_ready, 0);
    step();
    chk("t4_or_res1", rsp1_result, 7);
    chk("t4_hold_valid0", rsp0_valid, 1);
    chk("t4_hold_flags0", rsp0_flags, 4'b0010);
    rsp0_ready = 1;
    #1;
    chk("t4_reload_req0", req0_ready, 1);
    chk("t4_reload_req1", req1_ready, 0);
    step();
    chk("t4_reload_valid0", rsp0_valid, 1);
    chk("t4_reload_res0", rsp0_result, 100);
    chk("t4_count", grant_count, 8);

    // 5: signed overflow ADD, then three idle cycles.
    req1_valid = 0;
    req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = 4'b0000;
    step();
    req0_valid = 0;
    chk("t5_res0", rsp0_result, 32'h8000_0000);
    chk("t5_flags0", rsp0_flags, 4'b1001);
    chk("t5_count", grant_count, 9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_idle_ctrl", alu_ctrl, 0);
      chk("t5_idle_srcA", alu_srcA, 0);
      step();
    end
    chk("t5_idle_count", grant_count, 9);
    chk("t5_idle_rsp0", rsp0_valid, 0);

    // 6: reset with both slots full and a grant in flight.
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'b0000;
    step();
    chk("t6_full0", rsp0_valid, 1);
    chk("t6_full1", rsp1_valid, 1);
    rsp1_ready = 1;
    #1;
    chk("t6_pre_grant1", req1_ready, 1);
    rst = 1;
    #1;
    chk("t6_rst_req1_ready", req1_ready, 0);
    step();
    rst = 0;
    chk("t6_rsp0_valid", rsp0_valid, 0);
    chk("t6_rsp1_valid", rsp1_valid, 0);
    chk("t6_rsp1_result", rsp1_result, 0);
    chk("t6_count", grant_count, 0);
    req0_valid = 1; rsp0_ready = 1;
    #1;
    chk("t6_tie_req0", req0_ready, 1);
    chk("t6_tie_req1", req1_ready, 0);
    step();
    chk("t6_tie_rsp0", rsp0_valid, 1);
    chk("t6_tie_count", grant_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
